// File: rtl/apb_resp_pkg.sv
// Shared types and helpers for the APB SRAM responder: FSM states, LFSR
// constants and the byte-strobe merge used on SRAM writes.
package apb_resp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } resp_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  strb
  );
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/apb_resp_lfsr.sv
// 16-bit Fibonacci LFSR used to jitter the responder's wait-state count.
// Only instantiated when APB_RESP_RAND_WAIT_EN is defined.
module apb_resp_lfsr
  import apb_resp_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] value
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= LFSR_SEED;
    end else if (enable) begin
      value <= {value[14:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/apb_sram_responder.sv
// APB3/APB4 completer fronting a word-addressed SRAM window with byte strobes,
// fixed wait states and error response. Optional macro: APB_RESP_RAND_WAIT_EN.
module apb_sram_responder
  import apb_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 0,
  parameter int          WAIT_W      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic [2:0]  pprot,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr
);

  localparam int          IDX_W  = $clog2(DEPTH);
  localparam logic [31:0] WINDOW = 32'(DEPTH * 4);

  // Handshake: a transfer starts with psel=1/penable=0 (setup), then the
  // requester holds psel=1/penable=1 until pready=1 for exactly one cycle.
  // Dropping psel before pready abandons the transfer without side effects.

  resp_state_e state;
  resp_state_e state_next;

  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic              write_q;
  logic [WAIT_W-1:0] cnt;
  logic [WAIT_W-1:0] cnt_next;
  logic [WAIT_W-1:0] wait_load;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       off;
  logic [31:0]       rd_word;
  logic [IDX_W-1:0]  idx;
  logic              err;
  logic              setup;
  logic              commit;
  logic              mem_we;

  logic              pready_next;
  logic [31:0]       prdata_next;
  logic              pslverr_next;

  logic              unused_pprot;
  assign unused_pprot = ^pprot;

`ifdef APB_RESP_RAND_WAIT_EN
  localparam int SUM_W = WAIT_W + 1;

  logic [15:0]      lfsr_value;
  logic [SUM_W-1:0] wait_sum;
  logic             unused_lfsr;

  apb_resp_lfsr u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .enable (1'b1),
    .value  (lfsr_value)
  );

  // Saturate rather than wrap so jitter never shortens the programmed wait.
  assign wait_sum    = SUM_W'(WAIT_CYCLES) + SUM_W'(lfsr_value[2:0]);
  assign wait_load   = wait_sum[WAIT_W] ? '1 : wait_sum[WAIT_W-1:0];
  assign unused_lfsr = ^lfsr_value[15:3];
`else
  assign wait_load = WAIT_W'(WAIT_CYCLES);
`endif

  assign setup   = (state == IDLE) && psel && !penable;
  assign commit  = (state == ACCESS) && psel && (cnt == '0);

  // Unsigned wrap makes addresses below the base land far above the window.
  assign off     = addr_q - BASE_ADDR;
  assign idx     = off[IDX_W+1:2];
  assign err     = (off >= WINDOW) || (off[1:0] != 2'b00);
  assign rd_word = mem[idx];
  assign mem_we  = commit && write_q && !err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (setup) state_next = ACCESS;
      ACCESS: begin
        if (!psel) begin
          state_next = IDLE;
        end else if (cnt == '0) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pready_next  = commit;
    pslverr_next = commit && err;
    prdata_next  = '0;
    if (commit && !write_q && !err) prdata_next = rd_word;

    cnt_next = cnt;
    if (setup) begin
      cnt_next = wait_load;
    end else if ((state == ACCESS) && psel && (cnt != '0)) begin
      cnt_next = cnt - WAIT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
      cnt     <= '0;
    end else begin
      pready  <= pready_next;
      prdata  <= prdata_next;
      pslverr <= pslverr_next;
      cnt     <= cnt_next;
    end
  end

  // Request capture needs no reset: it is only consumed after a setup reloads it.
  always_ff @(posedge clock) begin
    if (setup) begin
      addr_q  <= paddr;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
      write_q <= pwrite;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[idx] <= merge_bytes(rd_word, wdata_q, strb_q);
  end

endmodule
